// File: rtl/vt_pkg.sv
// Shared types and byte constants for the VT100-style escape parser.
// Opcodes carry an OP_ prefix so they can coexist with the raw byte constants.
package vt_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_PRINT = 4'd1,
        OP_CR    = 4'd2,
        OP_LF    = 4'd3,
        OP_BS    = 4'd4,
        OP_TAB   = 4'd5,
        OP_CUU   = 4'd6,
        OP_CUD   = 4'd7,
        OP_CUF   = 4'd8,
        OP_CUB   = 4'd9,
        OP_CUP   = 4'd10,
        OP_ED    = 4'd11,
        OP_EL    = 4'd12,
        OP_SGR   = 4'd13
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_GROUND     = 2'd0,
        ST_ESCAPE     = 2'd1,
        ST_CSI_PARAM  = 2'd2,
        ST_CSI_IGNORE = 2'd3
    } state_e;

    localparam logic [7:0] ESC       = 8'h1B;
    localparam logic [7:0] CAN       = 8'h18;
    localparam logic [7:0] SUB       = 8'h1A;
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;
    localparam logic [7:0] BS        = 8'h08;
    localparam logic [7:0] TAB       = 8'h09;
    localparam logic [7:0] CSI_OPEN  = 8'h5B;
    localparam logic [7:0] PARAM_SEP = 8'h3B;

    // C0 controls that execute in every state except ESCAPE.
    function automatic cmd_op_e ctrl_op(input logic [7:0] b);
        case (b)
            CR:      return OP_CR;
            LF:      return OP_LF;
            BS:      return OP_BS;
            TAB:     return OP_TAB;
            default: return OP_NOP;
        endcase
    endfunction

    // Cursor counts and positions treat an absent or zero parameter as 1.
    function automatic logic [7:0] default_one(input logic [7:0] p);
        return (p == 8'd0) ? 8'd1 : p;
    endfunction

endpackage

// File: rtl/uart_escape_parser_if.sv
// Byte-in / command-out bundle of the escape parser.
interface uart_escape_parser_if;
    import vt_pkg::*;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cmd_valid;
    cmd_op_e    cmd_op;
    logic [7:0] cmd_char;
    logic [7:0] cmd_arg0;
    logic [7:0] cmd_arg1;
    logic [1:0] state_dbg;

    modport master (
        output rx_valid, rx_data,
        input  cmd_valid, cmd_op, cmd_char, cmd_arg0, cmd_arg1, state_dbg
    );

    modport slave (
        input  rx_valid, rx_data,
        output cmd_valid, cmd_op, cmd_char, cmd_arg0, cmd_arg1, state_dbg
    );

endinterface

// File: rtl/vt_param_accum.sv
// Saturating decimal accumulator for one CSI parameter: p = min(p*10 + d, PARAM_MAX).
module vt_param_accum #(
    parameter int PARAM_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_digit_en,
    input  logic [3:0] i_digit,
    output logic [7:0] o_value
);

    localparam logic [11:0] CEIL_12 = 12'(PARAM_MAX);
    localparam logic [7:0]  CEIL_8  = 8'(PARAM_MAX);

    logic [7:0]  r_value;
    logic [11:0] w_sum;

    // 12 bits hold 255*10+9 without wrapping, so the ceiling compare is exact.
    assign w_sum = ({4'd0, r_value} * 12'd10) + {8'd0, i_digit};

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_value <= 8'd0;
        end else if (i_digit_en) begin
            r_value <= (w_sum > CEIL_12) ? CEIL_8 : w_sum[7:0];
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/uart_escape_parser.sv
// Streaming VT100/ANSI escape parser: one UART byte per cycle in, at most one
// registered terminal command out on the following cycle.
module uart_escape_parser
    import vt_pkg::*;
#(
    parameter int PARAM_MAX = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_escape_parser_if.slave  bus
);

    state_e     r_state;
    logic [1:0] r_idx;
    logic       r_cmd_valid;
    cmd_op_e    r_op;
    logic [7:0] r_char;
    logic [7:0] r_arg0;
    logic [7:0] r_arg1;

    logic [7:0] w_p0;
    logic [7:0] w_p1;
    logic       w_clear;
    logic       w_dig0;
    logic       w_dig1;
    logic       w_is_digit;
    logic       w_printable;
    logic       w_final;
    logic       w_to_ignore;
    cmd_op_e    w_ctrl;
    cmd_op_e    w_final_op;
    logic [7:0] w_final_a0;
    logic [7:0] w_final_a1;

    always_comb begin
        w_is_digit  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
        w_printable = (bus.rx_data >= 8'h20) && (bus.rx_data <= 8'h7E);
        w_final     = (bus.rx_data >= 8'h40) && (bus.rx_data <= 8'h7E);
        w_to_ignore = ((bus.rx_data >= 8'h3C) && (bus.rx_data <= 8'h3F)) ||
                      ((bus.rx_data >= 8'h20) && (bus.rx_data <= 8'h2F));
        w_ctrl      = ctrl_op(bus.rx_data);
        w_clear     = bus.rx_valid && (r_state == ST_ESCAPE) && (bus.rx_data == CSI_OPEN);
        // Digits past the second parameter reach neither accumulator.
        w_dig0      = bus.rx_valid && (r_state == ST_CSI_PARAM) && w_is_digit && (r_idx == 2'd0);
        w_dig1      = bus.rx_valid && (r_state == ST_CSI_PARAM) && w_is_digit && (r_idx == 2'd1);
    end

    always_comb begin
        w_final_op = OP_NOP;
        w_final_a0 = w_p0;
        w_final_a1 = w_p1;
        case (bus.rx_data)
            8'h41: begin w_final_op = OP_CUU; w_final_a0 = default_one(w_p0); w_final_a1 = 8'd0; end
            8'h42: begin w_final_op = OP_CUD; w_final_a0 = default_one(w_p0); w_final_a1 = 8'd0; end
            8'h43: begin w_final_op = OP_CUF; w_final_a0 = default_one(w_p0); w_final_a1 = 8'd0; end
            8'h44: begin w_final_op = OP_CUB; w_final_a0 = default_one(w_p0); w_final_a1 = 8'd0; end
            8'h48, 8'h66: begin
                w_final_op = OP_CUP;
                w_final_a0 = default_one(w_p0);
                w_final_a1 = default_one(w_p1);
            end
            8'h4A: w_final_op = OP_ED;
            8'h4B: w_final_op = OP_EL;
            8'h6D: w_final_op = OP_SGR;
            default: ;
        endcase
    end

    vt_param_accum #(.PARAM_MAX(PARAM_MAX)) u_p0 (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_digit_en (w_dig0),
        .i_digit    (bus.rx_data[3:0]),
        .o_value    (w_p0)
    );

    vt_param_accum #(.PARAM_MAX(PARAM_MAX)) u_p1 (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_digit_en (w_dig1),
        .i_digit    (bus.rx_data[3:0]),
        .o_value    (w_p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_GROUND;
            r_idx       <= 2'd0;
            r_cmd_valid <= 1'b0;
            r_op        <= OP_NOP;
            r_char      <= 8'd0;
            r_arg0      <= 8'd0;
            r_arg1      <= 8'd0;
        end else begin
            r_cmd_valid <= 1'b0;
            if (bus.rx_valid) begin
                case (r_state)
                    ST_GROUND: begin
                        if (w_printable) begin
                            r_cmd_valid <= 1'b1;
                            r_op        <= OP_PRINT;
                            r_char      <= bus.rx_data;
                        end else if (w_ctrl != OP_NOP) begin
                            r_cmd_valid <= 1'b1;
                            r_op        <= w_ctrl;
                            r_char      <= 8'd0;
                        end else if (bus.rx_data == ESC) begin
                            r_state <= ST_ESCAPE;
                        end
                    end
                    ST_ESCAPE: begin
                        if (bus.rx_data == CSI_OPEN) begin
                            r_state <= ST_CSI_PARAM;
                            r_idx   <= 2'd0;
                        end else if (bus.rx_data != ESC) begin
                            r_state <= ST_GROUND;
                        end
                    end
                    default: begin
                        // CSI_PARAM and CSI_IGNORE share control-byte and abort handling.
                        if (w_ctrl != OP_NOP) begin
                            r_cmd_valid <= 1'b1;
                            r_op        <= w_ctrl;
                            r_char      <= 8'd0;
                        end else if (bus.rx_data == ESC) begin
                            r_state <= ST_ESCAPE;
                        end else if ((bus.rx_data == CAN) || (bus.rx_data == SUB)) begin
                            r_state <= ST_GROUND;
                        end else if (w_final) begin
                            r_state <= ST_GROUND;
                            if ((r_state == ST_CSI_PARAM) && (w_final_op != OP_NOP)) begin
                                r_cmd_valid <= 1'b1;
                                r_op        <= w_final_op;
                                r_char      <= 8'd0;
                                r_arg0      <= w_final_a0;
                                r_arg1      <= w_final_a1;
                            end
                        end else if (r_state == ST_CSI_PARAM) begin
                            if (bus.rx_data == PARAM_SEP) begin
                                r_idx <= (r_idx == 2'd2) ? 2'd2 : r_idx + 2'd1;
                            end else if (w_to_ignore) begin
                                r_state <= ST_CSI_IGNORE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_op    = r_op;
    assign bus.cmd_char  = r_char;
    assign bus.cmd_arg0  = r_arg0;
    assign bus.cmd_arg1  = r_arg1;
    assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_uart_escape_parser.sv
// Directed bench for uart_escape_parser: byte/expectation table plus reset corner cases,
// run against a default instance and a PARAM_MAX=100 instance fed the same bytes.
module tb_uart_escape_parser;
    import vt_pkg::*;

    typedef struct {
        logic [7:0] b;
        logic       ev;
        cmd_op_e    op;
        logic [7:0] ch;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [1:0] st;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vec[$];

    uart_escape_parser_if bus ();
    uart_escape_parser_if bus100 ();

    assign bus100.rx_valid = bus.rx_valid;
    assign bus100.rx_data  = bus.rx_data;

    uart_escape_parser #(.PARAM_MAX(255)) dut (.clk(clk), .rst(rst), .bus(bus));
    uart_escape_parser #(.PARAM_MAX(100)) dut100 (.clk(clk), .rst(rst), .bus(bus100));

    always #5 clk = ~clk;

    task automatic add_n(input logic [7:0] b, input logic [1:0] st);
        vec.push_back('{b: b, ev: 1'b0, op: OP_NOP, ch: 8'd0, a0: 8'd0, a1: 8'd0, st: st});
    endtask

    task automatic add_c(input logic [7:0] b, input cmd_op_e op, input logic [7:0] ch,
                         input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] st);
        vec.push_back('{b: b, ev: 1'b1, op: op, ch: ch, a0: a0, a1: a1, st: st});
    endtask

    task automatic add_csi_head();
        add_n(ESC, 2'd1);
        add_n("[", 2'd2);
    endtask

    task automatic check_zero(input string name);
        logic ok;
        checks++;
        ok = (bus.cmd_valid == 1'b0) && (bus.cmd_op == OP_NOP) && (bus.cmd_char == 8'd0) &&
             (bus.cmd_arg0 == 8'd0) && (bus.cmd_arg1 == 8'd0) && (bus.state_dbg == 2'd0) &&
             (bus100.cmd_valid == 1'b0) && (bus100.state_dbg == 2'd0);
        if (!ok) begin
            errors++;
            $display("FAIL %s: got vld=%0b op=%0d ch=%02h a0=%0d a1=%0d st=%0d, want all zero",
                     name, bus.cmd_valid, bus.cmd_op, bus.cmd_char, bus.cmd_arg0, bus.cmd_arg1,
                     bus.state_dbg);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       ok;
        logic [7:0] a0_100;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        add_c("H", OP_PRINT, 8'h48, 0, 0, 0);  add_c("i", OP_PRINT, 8'h69, 0, 0, 0);
        add_c(CR, OP_CR, 0, 0, 0, 0);          add_c(LF, OP_LF, 0, 0, 0, 0);
        add_csi_head(); add_n("1", 2); add_n("2", 2); add_n(";", 2); add_n("4", 2); add_n("0", 2);
        add_c("H", OP_CUP, 0, 12, 40, 0);
        add_csi_head(); add_c("H", OP_CUP, 0, 1, 1, 0);
        add_csi_head(); add_n(";", 2); add_n("5", 2); add_c("H", OP_CUP, 0, 1, 5, 0);
        add_csi_head(); add_n("9", 2); add_n("9", 2); add_n("9", 2); add_c("A", OP_CUU, 0, 255, 0, 0);
        add_csi_head(); add_n("2", 2); add_n("5", 2); add_n("6", 2); add_c("A", OP_CUU, 0, 255, 0, 0);
        add_csi_head(); add_n("0", 2); add_c("A", OP_CUU, 0, 1, 0, 0);
        add_csi_head(); add_n("1", 2); add_n(";", 2); add_n("2", 2); add_n(";", 2); add_n("3", 2);
        add_c("m", OP_SGR, 0, 1, 2, 0);
        add_csi_head(); add_n("?", 3); add_n("2", 3); add_n("5", 3); add_n("l", 0);
        add_c("x", OP_PRINT, 8'h78, 0, 0, 0);
        add_csi_head(); add_n("3", 2); add_c(LF, OP_LF, 0, 0, 0, 2); add_c("B", OP_CUD, 0, 3, 0, 0);
        add_csi_head(); add_n("5", 2); add_csi_head(); add_n("2", 2); add_c("C", OP_CUF, 0, 2, 0, 0);
        add_csi_head(); add_n("7", 2); add_n(CAN, 0); add_c("Z", OP_PRINT, 8'h5A, 0, 0, 0);
        add_csi_head(); add_c("J", OP_ED, 0, 0, 0, 0);
        add_csi_head(); add_n("2", 2); add_c("K", OP_EL, 0, 2, 0, 0);
        add_csi_head(); add_n("5", 2); add_c("D", OP_CUB, 0, 5, 0, 0);
        add_csi_head(); add_n("3", 2); add_n(";", 2); add_n("4", 2); add_c("f", OP_CUP, 0, 3, 4, 0);
        add_n(ESC, 1); add_csi_head(); add_n("4", 2); add_c("C", OP_CUF, 0, 4, 0, 0);
        add_n(ESC, 1); add_n("x", 0); add_n(8'h07, 0); add_n(8'h7F, 0);
        add_csi_head(); add_n("2", 2); add_n("Z", 0);
        add_csi_head(); add_n("?", 3); add_csi_head(); add_n("3", 2); add_c("B", OP_CUD, 0, 3, 0, 0);
        add_csi_head(); add_n("?", 3); add_c(CR, OP_CR, 0, 0, 0, 3); add_n("h", 0);
        add_csi_head(); add_n(SUB, 0);
        add_csi_head(); add_n(8'h20, 3); add_n("q", 0);
        add_c(TAB, OP_TAB, 0, 0, 0, 0);
        add_csi_head(); add_n("6", 2); add_c(BS, OP_BS, 0, 0, 0, 2); add_c("A", OP_CUU, 0, 6, 0, 0);
        add_c("!", OP_PRINT, 8'h21, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Table bytes go in back-to-back with rx_valid held high.
        for (int i = 0; i < vec.size(); i++) begin
            send(vec[i].b);
            checks++;
            a0_100 = (vec[i].a0 > 8'd100) ? 8'd100 : vec[i].a0;
            ok = (bus.cmd_valid == vec[i].ev) && (bus.state_dbg == vec[i].st) &&
                 (bus100.cmd_valid == vec[i].ev);
            if (vec[i].ev) begin
                ok = ok && (bus.cmd_op == vec[i].op) && (bus.cmd_char == vec[i].ch) &&
                     (bus100.cmd_op == vec[i].op);
                if (vec[i].op >= OP_CUU)
                    ok = ok && (bus.cmd_arg0 == vec[i].a0) && (bus100.cmd_arg0 == a0_100);
                if ((vec[i].op == OP_CUP) || (vec[i].op >= OP_ED))
                    ok = ok && (bus.cmd_arg1 == vec[i].a1);
            end
            if (!ok) begin
                errors++;
                $display("FAIL vec%0d byte=%02h: got vld=%0b op=%0d ch=%02h a0=%0d a1=%0d st=%0d a0_pm100=%0d, want vld=%0b op=%0d ch=%02h a0=%0d a1=%0d st=%0d a0_pm100=%0d",
                         i, vec[i].b, bus.cmd_valid, bus.cmd_op, bus.cmd_char, bus.cmd_arg0,
                         bus.cmd_arg1, bus.state_dbg, bus100.cmd_arg0, vec[i].ev, vec[i].op,
                         vec[i].ch, vec[i].a0, vec[i].a1, vec[i].st, a0_100);
            end
        end

        // Idle cycle: strobe drops, data holds the last command.
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (!((bus.cmd_valid == 1'b0) && (bus.cmd_op == OP_PRINT) && (bus.cmd_char == 8'h21))) begin
            errors++;
            $display("FAIL hold_after_cmd: got vld=%0b op=%0d ch=%02h, want vld=0 op=%0d ch=21",
                     bus.cmd_valid, bus.cmd_op, bus.cmd_char, OP_PRINT);
        end

        // Reset mid-sequence with a coincident byte, then a plain 'A'.
        send(ESC);
        send("[");
        send("4");
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = "1";
        @(posedge clk);
        #1;
        check_zero("reset_mid_csi");
        @(negedge clk);
        rst         = 1'b0;
        bus.rx_data = "A";
        @(posedge clk);
        #1;
        checks++;
        if (!((bus.cmd_valid == 1'b1) && (bus.cmd_op == OP_PRINT) && (bus.cmd_char == 8'h41) &&
              (bus.state_dbg == 2'd0) && (bus100.cmd_op == OP_PRINT))) begin
            errors++;
            $display("FAIL after_reset_A: got vld=%0b op=%0d ch=%02h st=%0d, want vld=1 op=%0d ch=41 st=0",
                     bus.cmd_valid, bus.cmd_op, bus.cmd_char, bus.state_dbg, OP_PRINT);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL strobe_one_cycle: got vld=%0b, want 0", bus.cmd_valid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_escape_parser.md
UART_ESCAPE_PARSER -- requirements
Module: uart_escape_parser

Interface
REQ-001 Parameter PARAM_MAX, default 255: saturation ceiling of each decimal CSI parameter; range 1..255.
REQ-002 clk  input  1  system clock; all logic on rising edge; one clock domain only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-005 rx_data  input  8  received byte; sampled only when rx_valid=1.
REQ-006 cmd_valid  output  1  one-cycle strobe: a decoded command is present on cmd_op/cmd_char/cmd_arg0/cmd_arg1.
REQ-007 cmd_op  output  4  command opcode from the vt_pkg enum: NOP, PRINT, CR, LF, BS, TAB, CUU, CUD, CUF, CUB, CUP, ED, EL, SGR.
REQ-008 cmd_char  output  8  character for PRINT; 0 otherwise.
REQ-009 cmd_arg0  output  8  first numeric argument.
REQ-010 cmd_arg1  output  8  second numeric argument.
REQ-011 state_dbg  output  2  current parser state, for seven-segment debug display.

Function
REQ-012 The parser state machine SHALL have four states: GROUND=0, ESCAPE=1, CSI_PARAM=2, CSI_IGNORE=3.
REQ-013 Each rx_valid byte SHALL be consumed in one cycle; the parser has no backpressure, and a byte arriving on every cycle SHALL be accepted.
REQ-014 When a byte produces a command, cmd_valid SHALL assert on the cycle after that byte's rx_valid, for exactly one cycle; data outputs are registered and hold their value until the next command.
REQ-015 GROUND state byte handling:
- 0x20-0x7E -> PRINT, cmd_char=byte.
- 0x0D -> CR; 0x0A -> LF; 0x08 -> BS; 0x09 -> TAB.
- 0x1B -> ESCAPE, no command.
- All other bytes -> ignored.
REQ-016 ESCAPE state byte handling:
- 0x5B '[' -> CSI_PARAM; clear both parameters and the parameter index.
- 0x1B -> stay in ESCAPE.
- Any other byte -> GROUND, no command.
REQ-017 CSI_PARAM digit handling:
- Digits 0x30-0x39 update the current parameter as p = min(p*10 + d, PARAM_MAX).
- Saturation SHALL be exact; a wrapped intermediate value is never allowed.
REQ-018 CSI_PARAM separator handling:
- 0x3B ';' advances the parameter index.
- Parameters beyond the second SHALL be parsed and discarded; arg0/arg1 are unaffected.
REQ-019 CSI_PARAM byte 0x3C-0x3F (private marker, e.g. '?') or 0x20-0x2F (intermediate) -> CSI_IGNORE.
REQ-020 CSI_PARAM final byte 0x40-0x7E -> GROUND, with the command below. An empty or missing parameter counts as 0 before defaulting.
- 'A','B','C','D' -> CUU/CUD/CUF/CUB; arg0 = p0, or 1 if p0=0.
- 'H' or 'f' -> CUP; arg0 = row, arg1 = col, each 1 if 0.
- 'J' -> ED; 'K' -> EL; 'm' -> SGR; arg0=p0 and arg1=p1 unmodified.
- Any other final byte -> no command.
REQ-021 CSI_IGNORE: bytes are discarded until a final byte 0x40-0x7E, then -> GROUND with no command.
REQ-022 In CSI_PARAM and CSI_IGNORE:
- 0x0D, 0x0A, 0x08 and 0x09 SHALL emit CR/LF/BS/TAB with no state or parameter change.
- 0x1B -> ESCAPE (sequence aborted).
- 0x18 (CAN) or 0x1A (SUB) -> GROUND, no command.
REQ-023 At most one command SHALL be produced per input byte; NOP is never emitted with cmd_valid=1.

Reset
REQ-024 While rst=1, on every clk edge:
- State -> GROUND.
- Parameters and index -> 0.
- cmd_valid=0, cmd_op=NOP, cmd_char=0, cmd_arg0=0, cmd_arg1=0, state_dbg=0.
REQ-025 rst SHALL take priority over a coincident rx_valid; that byte is dropped.
REQ-026 Reset mid-sequence SHALL leave no residue; a following "A" prints 'A'.

Structure
REQ-027 Package vt_pkg SHALL hold the opcode enum, the parser-state enum, and the byte constants ESC, CAN, SUB, CR, LF, BS and TAB.
REQ-028 Sub-module vt_param_accum SHALL implement the saturating decimal accumulate (clear, digit, ceiling PARAM_MAX) and be instantiated twice.
REQ-029 No FIFO SHALL be included; downstream consumes one command per cycle.

Verification
REQ-030 Bytes "Hi\r\n" back-to-back on consecutive cycles -> PRINT 0x48, PRINT 0x69, CR, LF; each cmd_valid one cycle after its byte.
REQ-031 ESC "[12;40H" -> single CUP arg0=12, arg1=40; ESC "[H" -> CUP 1,1; ESC "[;5H" -> CUP 1,5.
REQ-032 ESC "[999A" -> CUU arg0=255; with PARAM_MAX=100 -> arg0=100; ESC "[1;2;3m" -> SGR arg0=1, arg1=2.
REQ-033 ESC "[?25l" followed by "x" -> no command for the sequence, then PRINT 0x78; state_dbg observed 3 before 'l'.
REQ-034 ESC "[3" 0x0A "B" -> LF, then CUD arg0=3; ESC "[5" ESC "[2C" -> CUF arg0=2 only; ESC "[7" 0x18 "Z" -> PRINT 0x5A.
REQ-035 ESC "[4" then rst high one cycle coincident with rx_valid "1", then "A" -> PRINT 0x41; all outputs zero during reset.
